alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports instrValid input 1 / instrReady output 1  instruction handshake.
REQ-004 SHALL have ports instr input 32, regA input 32, regB input 32  instruction word and register-file operands.
REQ-005 SHALL have ports opCode output 5, dataA output 32, dataB output 32  drive to the ALU.
REQ-006 SHALL have ports dataC input 32, zero input 1, overflow input 1, error input 1  ALU return.
REQ-007 SHALL have ports resValid output 1 / resReady input 1, resData output 32, resDest output 5, resZero output 1, resErr output 1  result handshake.
REQ-008 SHALL have ports trap output 1, trapClear input 1  fault status and clear.

Function
REQ-009 SHALL decode instr: opCode=[31:27], rd=[26:22], imm=[15:0].
REQ-010 SHALL treat opcodes 00001,00011,00101,00111,01010,01100,01110,10011 as immediate: dataB = zero-extended imm; all other legal opcodes: dataB = regB.
REQ-011 SHALL always drive dataA = regA as captured at accept.
REQ-012 SHALL treat opcodes 10101..11111 as illegal.
REQ-013 SHALL implement FSM IDLE, EXEC, DONE, TRAP.
REQ-014 IDLE: instrReady=1; instrValid=1 captures instr/regA/regB into operand registers, -> EXEC.
REQ-015 EXEC: opCode/dataA/dataB held from operand registers; on that edge, capture dataC->resData, rd->resDest, zero->resZero, error->resErr, -> DONE (or TRAP per REQ-024).
REQ-016 Illegal opcode accepted in IDLE SHALL go IDLE->EXEC->TRAP without capturing dataC; resData=0, resErr=1.
REQ-017 DONE: resValid=1, result outputs stable; resReady=1 -> IDLE; no new accept in same cycle.
REQ-018 Latency: accept edge to resValid high = 2 cycles; throughput 1 instruction per 3 cycles minimum.
REQ-019 instrReady SHALL be 0 in EXEC, DONE, TRAP.
REQ-020 opCode/dataA/dataB SHALL hold last values outside EXEC (no glitching to ALU).
REQ-021 resValid SHALL stay high, resData stable, until resReady sampled high.

Reset
REQ-022 resetN low SHALL immediately force IDLE, instrReady=1 after release, resValid=0, trap=0, resErr=0, resZero=0, resData=0, resDest=0, opCode=0, dataA=0, dataB=0.
REQ-023 Reset mid-EXEC or mid-DONE SHALL discard the in-flight instruction with no result delivered.

Configuration
REQ-024 With ALU_ERR_TRAP_EN defined: error=1 or illegal opcode in EXEC -> TRAP; trap=1, resValid=0; trapClear=1 -> IDLE, trap=0; instrValid ignored in TRAP.
REQ-025 Without ALU_ERR_TRAP_EN: no TRAP state reachable; faults go to DONE with resErr=1 delivered normally; trap tied 0, trapClear ignored.

Structure
REQ-026 SHALL place opcode constants, field bit positions, immediate-opcode list and FSM state encoding in shared package alu_pkg.
REQ-027 SHALL implement field extraction, immediate select and illegal check as combinational sub-module alu_instr_decode.
REQ-028 Target size 120-400 RTL lines.

Verification
REQ-029 ADD reg: instr opCode=00000 rd=3, regA=5, regB=7, dataC loopback=12 -> resValid 2 cycles after accept, resData=12, resDest=3, resZero=0.
REQ-030 ANDI: opCode=01100, imm=0xFFFF, regA=0x1234_5678, regB=0xDEAD_BEEF -> dataB=0x0000_FFFF during EXEC, resData=0x5678.
REQ-031 DIV by zero: opCode=00110, regB=0, ALU error=1 -> trap=1 (ALU_ERR_TRAP_EN) until trapClear, else resErr=1, resData=0.
REQ-032 Illegal opcode 11000 -> resErr=1/trap per REQ-024/025, dataC ignored.
REQ-033 Backpressure: resReady=0 for 5 cycles in DONE -> resValid and resData stable, instrReady=0 throughout; release -> IDLE next cycle.
REQ-034 resetN low during EXEC -> no resValid pulse, instrReady=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, field positions, state encoding and bundles for the ALU dispatcher.
package alu_pkg;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RD_MSB  = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [4:0] OP_ADD     = 5'b00000;
    localparam logic [4:0] OP_DIV     = 5'b00110;
    localparam logic [4:0] OP_ANDI    = 5'b01100;
    localparam logic [4:0] OP_ILL_MIN = 5'b10101;

    localparam int unsigned N_IMM_OPS = 8;
    localparam logic [N_IMM_OPS-1:0][4:0] IMM_OPS = {
        5'b00001, 5'b00011, 5'b00101, 5'b00111,
        5'b01010, OP_ANDI,  5'b01110, 5'b10011
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2,
        ST_TRAP = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] b;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        illegal;
    } opnd_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        zero;
        logic        err;
    } res_t;

    function automatic logic is_imm_op(input logic [4:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IMM_OPS; i++) begin
            hit = hit | (op == IMM_OPS[i]);
        end
        return hit;
    endfunction

    function automatic logic is_illegal_op(input logic [4:0] op);
        return op >= OP_ILL_MIN;
    endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational instruction decode: field extraction, operand-B select, illegal check.
module alu_instr_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] reg_b,
    output dec_t        dec
);

    logic [4:0]  op;
    logic [15:0] imm;
    logic        unused_bits;

    assign op  = instr[OPC_MSB:OPC_LSB];
    assign imm = instr[IMM_MSB:IMM_LSB];

    // bits between rd and imm carry no meaning for this unit
    assign unused_bits = ^instr[RD_LSB-1:IMM_MSB+1];

    always_comb begin
        dec         = '0;
        dec.op      = op;
        dec.rd      = instr[RD_MSB:RD_LSB];
        dec.illegal = is_illegal_op(op);
        dec.b       = is_imm_op(op) ? {16'h0000, imm} : reg_b;
    end

endmodule

// File: rtl/alu_dispatch.sv
// Single-issue ALU dispatcher: capture, execute, hold result until consumed.
// Define ALU_ERR_TRAP_EN to divert ALU errors and illegal opcodes into a sticky TRAP state.
module alu_dispatch
    import alu_pkg::*;
(
    input  logic        clock,
    input  logic        resetN,
    input  logic        instrValid,
    output logic        instrReady,
    input  logic [31:0] instr,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    output logic [4:0]  opCode,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    input  logic [31:0] dataC,
    input  logic        zero,
    input  logic        overflow,
    input  logic        error,
    output logic        resValid,
    input  logic        resReady,
    output logic [31:0] resData,
    output logic [4:0]  resDest,
    output logic        resZero,
    output logic        resErr,
    output logic        trap,
    input  logic        trapClear
);

    dec_t   dec;
    state_e state_q, state_d;
    opnd_t  opnd_q, opnd_d;
    res_t   res_q, res_d;
    logic   unused_ok;

    alu_instr_decode u_decode (
        .instr (instr),
        .reg_b (regB),
        .dec   (dec)
    );

    // overflow has no role in the result record
    assign unused_ok = ^{overflow, trapClear};

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        res_d      = res_q;
        instrReady = 1'b0;
        resValid   = 1'b0;
        trap       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                instrReady = 1'b1;
                if (instrValid) begin
                    opnd_d.op      = dec.op;
                    opnd_d.rd      = dec.rd;
                    opnd_d.a       = regA;
                    opnd_d.b       = dec.b;
                    opnd_d.illegal = dec.illegal;
                    state_d        = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d.dest = opnd_q.rd;
                if (opnd_q.illegal) begin
                    res_d.data = '0;
                    res_d.zero = 1'b0;
                    res_d.err  = 1'b1;
                end else begin
                    res_d.data = dataC;
                    res_d.zero = zero;
                    res_d.err  = error;
                end
`ifdef ALU_ERR_TRAP_EN
                state_d = (opnd_q.illegal || error) ? ST_TRAP : ST_DONE;
`else
                state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                resValid = 1'b1;
                if (resReady) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP: begin
`ifdef ALU_ERR_TRAP_EN
                trap = 1'b1;
                if (trapClear) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
        end
    end

    assign opCode  = opnd_q.op;
    assign dataA   = opnd_q.a;
    assign dataB   = opnd_q.b;
    assign resData = res_q.data;
    assign resDest = res_q.dest;
    assign resZero = res_q.zero;
    assign resErr  = res_q.err;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small ALU stand-in and a result scoreboard.
module tb_alu_dispatch;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [4:0]  opCode;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataC;
    logic        zero;
    logic        overflow;
    logic        error;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic [4:0]  resDest;
    logic        resZero;
    logic        resErr;
    logic        trap;
    logic        trapClear;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    alu_dispatch dut (
        .clock      (clock),
        .resetN     (resetN),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instr      (instr),
        .regA       (regA),
        .regB       (regB),
        .opCode     (opCode),
        .dataA      (dataA),
        .dataB      (dataB),
        .dataC      (dataC),
        .zero       (zero),
        .overflow   (overflow),
        .error      (error),
        .resValid   (resValid),
        .resReady   (resReady),
        .resData    (resData),
        .resDest    (resDest),
        .resZero    (resZero),
        .resErr     (resErr),
        .trap       (trap),
        .trapClear  (trapClear)
    );

    function automatic logic imm_op(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00011, 5'b00101, 5'b00111,
            5'b01010, 5'b01100, 5'b01110, 5'b10011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu_fn(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        if (op >= 5'b10101) return 32'hBAD0_BAD0;
        if (op == 5'b01100) return a & b;
        if (op == 5'b00110) return (b == 0) ? 32'h0 : a / b;
        return a + b;
    endfunction

    function automatic logic [31:0] exp_b(input logic [31:0] ins,
                                          input logic [31:0] b);
        return imm_op(ins[31:27]) ? {16'h0, ins[15:0]} : b;
    endfunction

    function automatic exp_t model(input logic [31:0] ins,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        r;
        logic [4:0]  op;
        logic [31:0] bb;
        op     = ins[31:27];
        bb     = exp_b(ins, b);
        r.dest = ins[26:22];
        r.zero = 1'b0;
        r.err  = 1'b0;
        r.data = 32'h0;
        if (op >= 5'b10101 || (op == 5'b00110 && bb == 0)) begin
            r.err = 1'b1;
        end else begin
            r.data = alu_fn(op, a, bb);
            r.zero = (r.data == 0);
        end
        return r;
    endfunction

    // ALU stand-in driven by the dispatcher's operand outputs
    always_comb begin
        dataC    = alu_fn(opCode, dataA, dataB);
        error    = (opCode == 5'b00110) && (dataB == 0);
        zero     = (dataC == 0) && !error;
        overflow = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clock); #1;
        chk("rdy_idle", instrReady, 1);
        instr      = ins;
        regA       = a;
        regB       = b;
        instrValid = 1'b1;
        sb.push_back(model(ins, a, b));
        @(posedge clock); #1;
        instrValid = 1'b0;
        instr      = $urandom;
        regA       = $urandom;
        regB       = $urandom;
        chk("rdy_exec", instrReady, 0);
        chk("vld_exec", resValid, 0);
        chk("opc_exec", opCode, ins[31:27]);
        chk("dA_exec", dataA, a);
        chk("dB_exec", dataB, exp_b(ins, b));
    endtask

    task automatic collect(input int hold);
        exp_t        e;
        logic [31:0] d0;
        @(posedge clock); #1;
        chk("vld_lat", resValid, 1);
        chk("rdy_done", instrReady, 0);
        chk("trap_done", trap, 0);
        chk("sb_ready", sb.size() != 0, 1);
        e = '{default: '0};
        if (sb.size() != 0) e = sb.pop_front();
        chk("res_data", resData, e.data);
        chk("res_dest", resDest, e.dest);
        chk("res_zero", resZero, e.zero);
        chk("res_err", resErr, e.err);
        d0 = resData;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("vld_hold", resValid, 1);
            chk("data_hold", resData, d0);
            chk("rdy_hold", instrReady, 0);
        end
        resReady = 1'b1;
        @(posedge clock); #1;
        resReady = 1'b0;
        chk("vld_rel", resValid, 0);
        chk("rdy_rel", instrReady, 1);
    endtask

    task automatic fault(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        issue(ins, a, b);
`ifdef ALU_ERR_TRAP_EN
        begin
            exp_t e;
            @(posedge clock); #1;
            chk("trap_set", trap, 1);
            chk("trap_vld", resValid, 0);
            chk("trap_err", resErr, 1);
            e = '{default: '0};
            if (sb.size() != 0) e = sb.pop_front();
            chk("trap_model_err", e.err, 1);
            instrValid = 1'b1;
            repeat (3) begin
                @(posedge clock); #1;
                chk("trap_stick", trap, 1);
                chk("trap_rdy", instrReady, 0);
            end
            instrValid = 1'b0;
            trapClear  = 1'b1;
            @(posedge clock); #1;
            trapClear = 1'b0;
            chk("trap_clr", trap, 0);
            chk("trap_rdy_clr", instrReady, 1);
        end
`else
        collect(0);
`endif
    endtask

    task automatic reset_mid(input int extra);
        issue({5'b00000, 5'd12, 22'd0}, 32'd9, 32'd9);
        repeat (extra) begin
            @(posedge clock); #1;
        end
        resetN = 1'b0;
        #1;
        chk("rst_vld", resValid, 0);
        chk("rst_rdy", instrReady, 1);
        chk("rst_data", resData, 0);
        chk("rst_opc", opCode, 0);
        @(posedge clock); #1;
        resetN = 1'b1;
        sb.delete();
        repeat (3) begin
            @(posedge clock); #1;
            chk("post_rst_vld", resValid, 0);
            chk("post_rst_rdy", instrReady, 1);
        end
    endtask

    initial begin
        resetN     = 1'b0;
        instrValid = 1'b0;
        instr      = 32'h0;
        regA       = 32'h0;
        regB       = 32'h0;
        resReady   = 1'b0;
        trapClear  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rdy", instrReady, 1);
        chk("rst_vld", resValid, 0);
        chk("rst_trap", trap, 0);
        chk("rst_err", resErr, 0);
        chk("rst_zero", resZero, 0);
        chk("rst_data", resData, 0);
        chk("rst_dest", resDest, 0);
        chk("rst_opc", opCode, 0);
        chk("rst_dA", dataA, 0);
        chk("rst_dB", dataB, 0);
        resetN = 1'b1;

        issue({5'b00000, 5'd3, 22'd0}, 32'd5, 32'd7);
        collect(0);
        issue({5'b01100, 5'd9, 6'd0, 16'hFFFF}, 32'h1234_5678, 32'hDEAD_BEEF);
        collect(0);
        issue({5'b00000, 5'd31, 22'd0}, 32'hFFFF_FFFF, 32'd1);
        collect(0);
        issue({5'b00001, 5'd7, 6'd0, 16'h8001}, 32'h10, 32'hFFFF_FFFF);
        collect(5);
        issue({5'b00010, 5'd1, 6'h3F, 16'h1234}, 32'd100, 32'd23);
        collect(1);
        issue({5'b10100, 5'd2, 22'd0}, 32'd1, 32'd2);
        collect(0);
        issue({5'b10011, 5'd5, 6'd0, 16'h0004}, 32'd1, 32'hFFFF_0000);
        collect(0);
        issue({5'b00110, 5'd8, 22'd0}, 32'd50, 32'd5);
        collect(0);

        fault({5'b00110, 5'd4, 22'd0}, 32'd50, 32'd0);
        fault({5'b11000, 5'd6, 22'd0}, 32'd3, 32'd4);
        fault({5'b10101, 5'd10, 22'd0}, 32'd3, 32'd4);

        reset_mid(0);
        reset_mid(1);

        issue({5'b00000, 5'd3, 22'd0}, 32'd20, 32'd22);
        collect(0);

        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
